ddp_tx_packer: RTL



---
 rtl/ddp_tx_packer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ddp_tx_packer.sv
// rtl/ddp_tx_packer.sv - packs 64-bit DMA packet words into 267-bit DDP beats
// for the gearbox TX FIFO, with packet/error statistics and oversize flag.
module ddp_tx_packer #(
  parameter int MAX_BEATS = 64,
  parameter int CNT_W     = 32
) (
  input  logic              clock,
  input  logic              realResetN,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [2:0]        in_empty,
  input  logic [63:0]       in_data,
  output logic [266:0]      ddpPktDataIn,
  output logic              ddpPktPush,
  input  logic              ddpPktFull,
  output logic [CNT_W-1:0]  pktCount,
  output logic [CNT_W-1:0]  errCount,
  output logic              oversize
);

  localparam int BW = $clog2(MAX_BEATS + 2);

  logic [1:0]       ptr_q, ptr_d;
  logic [63:0]      slot_q [3];
  logic             sop_seen_q, sop_seen_d;
  logic             in_pkt_q, in_pkt_d;
  logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [266:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             oversize_q, oversize_d;

  logic         accept, drop, sop_err, take, start, complete;
  logic [8:0]   byte_cnt;
  logic [255:0] beat_data;

  assign ddpPktPush   = out_valid_q & ~ddpPktFull;
  assign in_ready     = ~out_valid_q | ~ddpPktFull;
  assign ddpPktDataIn = out_data_q;
  assign pktCount     = pkt_cnt_q;
  assign errCount     = err_cnt_q;
  assign oversize     = oversize_q;

  assign accept   = in_valid & in_ready;
  assign drop     = accept & ~in_pkt_q & ~in_sop;
  assign sop_err  = accept & in_pkt_q & in_sop;
  assign take     = accept & ~drop;
  assign start    = take & ~in_pkt_q;
  assign complete = take & ((ptr_q == 2'd3) | in_eop);

  assign byte_cnt = in_eop ? ({4'b0, ptr_q, 3'b0} + {5'b0, 4'd8 - {1'b0, in_empty}})
                           : 9'd32;

  // Final word goes straight into the beat so completion adds no latency.
  always_comb begin
    beat_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < ptr_q) beat_data[255-64*i -: 64] = slot_q[i];
    end
    case (ptr_q)
      2'd0:    beat_data[255:192] = in_data;
      2'd1:    beat_data[191:128] = in_data;
      2'd2:    beat_data[127:64]  = in_data;
      default: beat_data[63:0]    = in_data;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    sop_seen_d  = sop_seen_q;
    in_pkt_d    = in_pkt_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q & ~ddpPktPush;
    out_data_d  = out_data_q;
    pkt_cnt_d   = pkt_cnt_q;
    err_cnt_d   = err_cnt_q;
    oversize_d  = 1'b0;

    if (drop || sop_err) err_cnt_d = err_cnt_q + CNT_W'(1);
    if (ddpPktPush && out_data_q[265]) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);

    if (take) begin
      in_pkt_d = ~in_eop;
      if (complete) begin
        ptr_d       = 2'd0;
        sop_seen_d  = 1'b0;
        out_valid_d = 1'b1;
        out_data_d  = {sop_seen_q | start, in_eop, byte_cnt, beat_data};
        oversize_d  = (beat_cnt_q == BW'(MAX_BEATS));
        if (in_eop)
          beat_cnt_d = '0;
        else if (beat_cnt_q != BW'(MAX_BEATS + 1))
          beat_cnt_d = beat_cnt_q + BW'(1);
      end else begin
        ptr_d      = ptr_q + 2'd1;
        sop_seen_d = sop_seen_q | start;
      end
    end
  end

  always_ff @(posedge clock or negedge realResetN) begin
    if (!realResetN) begin
      ptr_q       <= '0;
      sop_seen_q  <= 1'b0;
      in_pkt_q    <= 1'b0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
      oversize_q  <= 1'b0;
      for (int i = 0; i < 3; i++) slot_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      sop_seen_q  <= sop_seen_d;
      in_pkt_q    <= in_pkt_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
      oversize_q  <= oversize_d;
      if (take && !complete) slot_q[ptr_q] <= in_data;
    end
  end

endmodule
